icache_responder: RTL and testbench

Direct-mapped, one-word-block instruction cache that answers the pipeline's instruction fetch requests (`imemREN`/`imemaddr` in, `ihit`/`imemload` out) and refills misses from the memory controller over a blocking read port (`iREN`/`iaddr` out, `iwait`/`iload` in). It sits between the datapath fetch stage and the memory arbiter, on the cache side of the datapath–cache interface. It also keeps hit and miss counters for the performance-count dump at halt.

---
 rtl/icache_responder_if.sv | 27 ++
 rtl/icache_responder.sv | 129 ++++++++++++
 tb/tb_icache_responder.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
// Fetch/refill bus between the datapath, the instruction cache and the memory arbiter.
//   imemREN/imemaddr : fetch request from the datapath
//   ihit/imemload    : fetch response back to the datapath
//   iREN/iaddr       : refill read request to the memory controller
//   iwait/iload      : memory busy flag and refill data
// slave  : cache side (answers fetches, issues refills)
// master : environment side (datapath + memory controller)
interface icache_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-block instruction cache with blocking refill and
// hit/miss performance counters.
//   CLK, RST    : clock and synchronous active-high reset
//   bus (slave) : fetch request/response and memory refill port
//   hit_count   : cycles in which ihit was asserted (wraps)
//   miss_count  : refills started (wraps)
module icache_responder #(
    parameter int unsigned NFRAMES = 16
) (
    input  logic                CLK,
    input  logic                RST,
    icache_responder_if.slave   bus,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);

    localparam int unsigned IDX  = $clog2(NFRAMES);
    localparam int unsigned TAGW = 30 - IDX;

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [NFRAMES-1:0]  r_valid;
    logic [TAGW-1:0]     r_tag  [NFRAMES];
    logic [31:0]         r_data [NFRAMES];
    logic [31:0]         r_miss_addr;
    logic [31:0]         r_hit_count;
    logic [31:0]         r_miss_count;

    logic [TAGW-1:0]     w_req_tag;
    logic [IDX-1:0]      w_req_idx;
    logic [TAGW-1:0]     w_miss_tag;
    logic [IDX-1:0]      w_miss_idx;
    logic                w_match;
    logic                w_ihit;
    logic [31:0]         w_imemload;
    logic                w_iren;
    logic [31:0]         w_iaddr;
    logic                w_start_miss;
    logic                w_fill;
    logic [1:0]          w_unused_addr_bits;

    // Address split for the live request and the latched miss
    assign w_req_tag          = bus.imemaddr[31:IDX+2];
    assign w_req_idx          = bus.imemaddr[IDX+1:2];
    assign w_miss_tag         = r_miss_addr[31:IDX+2];
    assign w_miss_idx         = r_miss_addr[IDX+1:2];
    assign w_unused_addr_bits = bus.imemaddr[1:0];

    // Combinational lookup so a hit is answered in the request cycle
    assign w_match = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        w_ihit       = 1'b0;
        w_imemload   = 32'd0;
        w_iren       = 1'b0;
        w_iaddr      = 32'd0;
        w_start_miss = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.imemREN) begin
                    if (w_match) begin
                        w_ihit     = 1'b1;
                        w_imemload = r_data[w_req_idx];
                    end else begin
                        w_start_miss = 1'b1;
                        w_next_state = FETCH;
                    end
                end
            end
            FETCH: begin
                // Request inputs are ignored here; the refill always completes
                w_iren  = 1'b1;
                w_iaddr = r_miss_addr;
                if (!bus.iwait) begin
                    w_fill       = 1'b1;
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    // State, valid bits, miss address and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_addr  <= 32'd0;
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_start_miss) begin
                r_miss_addr  <= {bus.imemaddr[31:2], 2'b00};
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (w_ihit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_fill) begin
                r_valid[w_miss_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays carry no reset; a reset during refill suppresses the write
    always_ff @(posedge CLK) begin
        if (w_fill && !RST) begin
            r_tag[w_miss_idx]  <= w_miss_tag;
            r_data[w_miss_idx] <= bus.iload;
        end
    end

    assign bus.ihit     = w_ihit;
    assign bus.imemload = w_imemload;
    assign bus.iREN     = w_iren;
    assign bus.iaddr    = w_iaddr;
    assign hit_count    = r_hit_count;
    assign miss_count   = r_miss_count;

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus random
// fetch traffic against a dictionary-style cache model and a wait-state memory.
module tb_icache_responder;

    localparam int unsigned NFRAMES = 16;
    localparam int unsigned IDX     = 4;

    logic        CLK;
    logic        RST;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_responder_if bus();

    icache_responder #(.NFRAMES(NFRAMES)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          miss;
        bit          fill_only;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model: which tag each frame holds, plus expected counters
    bit          m_valid [NFRAMES];
    logic [31:0] m_tag   [NFRAMES];
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    int          forced_waits = 3;
    int          cur_waits    = 0;
    int          fetch_cyc    = 0;
    int          fetch_len    = 0;
    bit          fetch_seen   = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C22_0004;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(NFRAMES); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 32'd0;
        end
        m_hits   = 32'd0;
        m_misses = 32'd0;
    endtask

    // Predict the outcome of a request and queue it for the monitor
    task automatic expect_req(input logic [31:0] addr, input bit fill_only);
        exp_t        e;
        logic [31:0] a;
        logic [31:0] tag;
        int          idx;
        a   = addr & 32'hFFFF_FFFC;
        idx = int'((a >> 2) % NFRAMES);
        tag = a >> (IDX + 2);
        e.addr      = a;
        e.data      = mem_word(a);
        e.fill_only = fill_only;
        e.miss      = !(m_valid[idx] && m_tag[idx] == tag);
        if (e.miss) begin
            m_misses     = m_misses + 32'd1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
        e.mc = m_misses;
        e.hc = m_hits;
        if (!fill_only) m_hits = m_hits + 32'd1;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the reset edge
    task automatic do_reset();
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'd0;
        RST          = 1'b1;
        exp_q.delete();
        model_clear();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Wait for the current request to hit, then hold it for extra hit cycles
    task automatic wait_hit(input logic [31:0] addr, input int extra);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge CLK);
            if (bus.ihit === 1'b1) got = 1'b1;
            n++;
        end
        if (!got) begin
            fail("hit_timeout");
            @(posedge CLK);
            #1;
            do_reset();
        end else begin
            for (int i = 0; i < extra; i++) begin
                expect_req(addr, 1'b0);
                @(negedge CLK);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] addr, input int extra);
        expect_req(addr, 1'b0);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        wait_hit(addr, extra);
    endtask

    // Memory controller: per-refill wait count, garbage data while busy
    always @(posedge CLK) begin
        #1;
        if (bus.iREN === 1'b1) begin
            if (fetch_cyc == 0)
                cur_waits = (forced_waits >= 0) ? forced_waits : int'($urandom_range(0, 3));
            fetch_cyc++;
            bus.iwait = (fetch_cyc <= cur_waits);
        end else begin
            fetch_cyc = 0;
            bus.iwait = 1'($urandom_range(0, 1));
        end
        bus.iload = bus.iwait ? $urandom : mem_word(bus.iaddr);
    end

    // Monitor: pops the scoreboard on every hit and on refill-only completions
    always @(negedge CLK) begin
        if (RST !== 1'b0) begin
            fetch_len  = 0;
            fetch_seen = 1'b0;
        end else begin
            if (bus.iREN === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_refill");
                end else begin
                    check("iaddr", bus.iaddr, exp_q[0].addr);
                    fetch_len++;
                    fetch_seen = 1'b1;
                    if (bus.iwait === 1'b0) begin
                        check("fetch_len", 32'(fetch_len), 32'(cur_waits + 1));
                        fetch_len = 0;
                        if (exp_q[0].fill_only) begin
                            void'(exp_q.pop_front());
                            fetch_seen = 1'b0;
                        end
                    end
                end
            end else begin
                check("iaddr_idle", bus.iaddr, 32'd0);
            end
            if (bus.ihit === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].fill_only) begin
                    fail("unexpected_hit");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("imemload", bus.imemload, e.data);
                    check("miss_path", 32'(fetch_seen), 32'(e.miss));
                    check("hit_count", hit_count, e.hc);
                    check("miss_count", miss_count, e.mc);
                    fetch_seen = 1'b0;
                end
            end else begin
                check("imemload_nohit", bus.imemload, 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        RST          = 1'b1;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'd0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        check("rst_ihit", 32'(bus.ihit), 32'd0);
        check("rst_imemload", bus.imemload, 32'd0);
        check("rst_iREN", 32'(bus.iREN), 32'd0);
        check("rst_iaddr", bus.iaddr, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);

        // Cold miss with 3 wait cycles, then 5 more back-to-back hits
        forced_waits = 3;
        issue(32'h0000_0040, 5);
        check("b2b_hit_count", hit_count, 32'd6);

        // Conflict eviction on index 0
        issue(32'h0000_0080, 0);
        issue(32'h0000_0040, 0);
        check("evict_miss_count", miss_count, 32'd3);

        // Redirect during refill
        do_reset();
        forced_waits = 3;
        expect_req(32'h0000_0100, 1'b1);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0100;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        bus.imemaddr = 32'h0000_0200;
        expect_req(32'h0000_0200, 1'b0);
        wait_hit(32'h0000_0200, 0);
        issue(32'h0000_0104, 1);

        // Reset in the middle of a refill, then minimum-latency miss
        do_reset();
        forced_waits = 6;
        expect_req(32'h0000_0300, 1'b0);
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0300;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("pre_rst_iREN", 32'(bus.iREN), 32'd1);
        do_reset();
        check("post_rst_iREN", 32'(bus.iREN), 32'd0);
        check("post_rst_miss_count", miss_count, 32'd0);
        forced_waits = 0;
        issue(32'h0000_0300, 0);
        check("refetch_miss_count", miss_count, 32'd1);

        // Idle pipeline with an uncached address
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0000_ABC0;
        repeat (4) begin
            @(negedge CLK);
            check("idle_ihit", 32'(bus.ihit), 32'd0);
            check("idle_iREN", 32'(bus.iREN), 32'd0);
        end
        @(posedge CLK); #1;
        check("idle_hit_count", hit_count, m_hits);
        check("idle_miss_count", miss_count, m_misses);

        // Random traffic over a few tags per index
        forced_waits = -1;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.imemREN  = 1'b0;
                bus.imemaddr = $urandom;
                @(posedge CLK); #1;
            end else begin
                a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
                    | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_0000);
                issue(a, int'($urandom_range(0, 2)));
            end
        end
        bus.imemREN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("final_hit_count", hit_count, m_hits);
        check("final_miss_count", miss_count, m_misses);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
